// File: rtl/btn_status_pkg.sv
// Shared layout constants and types for the button status block.
// Status word and acknowledge word bit positions live here so software headers can mirror them.
package btn_status_pkg;

  localparam int LVL_LSB   = 0;
  localparam int PRESS_LSB = 4;
  localparam int REL_LSB   = 6;
  localparam int CNT0_LSB  = 8;
  localparam int CNT1_LSB  = 16;
  localparam int ID_LSB    = 24;

  localparam int ACK_FLAG_LSB = 0;
  localparam int ACK_CNT_LSB  = 8;

  localparam int         CNT_W         = 8;
  localparam logic [7:0] BTN_STATUS_ID = 8'hB5;

  // Per-button debounce response: stable level plus one-cycle edge pulses.
  typedef struct packed {
    logic d;
    logic press;
    logic rel;
  } btn_evt_t;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, counter debounce into stable level d,
// and registered one-cycle press/release pulses issued on the cycle d changes.
module btn_debounce
  import btn_status_pkg::*;
#(
  parameter int unsigned p_CNT_DEBOUNCE = 500_000
) (
  input  logic     clock,
  input  logic     resetn,
  input  logic     btn_n,
  output btn_evt_t evt
);

  localparam int            CW       = $clog2(p_CNT_DEBOUNCE);
  localparam logic [CW-1:0] CNT_LAST = CW'(p_CNT_DEBOUNCE - 1);

  logic          sync1, s, d, press_q, rel_q;
  logic [CW-1:0] cnt;

  // Sync flops and d reset to "released" so leaving reset never looks like a press.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1   <= 1'b1;
      s       <= 1'b1;
      d       <= 1'b1;
      cnt     <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1   <= btn_n;
      s       <= sync1;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      if (s == d) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        d       <= s;
        cnt     <= '0;
        press_q <= ~s;
        rel_q   <= s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign evt = '{d: d, press: press_q, rel: rel_q};

endmodule

// File: rtl/btn_status.sv
// Push-button status return path: debounced levels, sticky event flags and
// press counters in a 32-bit status word. Optional macro BTN_RELEASE_EVT_EN adds release flags.
module btn_status
  import btn_status_pkg::*;
#(
  parameter int          N_BTN          = 2,
  parameter int unsigned p_CNT_DEBOUNCE = 500_000
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [N_BTN-1:0] btn_n,
  input  logic [31:0]      xack,
  output logic [31:0]      xstat,
  output logic             evt_irq
);

  if (N_BTN < 1 || N_BTN > 2) begin : g_bad_n_btn
    $error("btn_status: N_BTN must be 1 or 2");
  end

  btn_evt_t [N_BTN-1:0]            evt;
  logic     [N_BTN-1:0]            lvl, press_p, rel_p, press_flag, rel_flag;
  logic     [N_BTN-1:0][CNT_W-1:0] press_cnt;
  logic     [31:0]                 ack_r, ack_prev, ack_edge;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(.p_CNT_DEBOUNCE(p_CNT_DEBOUNCE)) u_db (
      .clock  (clock),
      .resetn (resetn),
      .btn_n  (btn_n[g]),
      .evt    (evt[g])
    );
    assign lvl[g]     = ~evt[g].d;
    assign press_p[g] = evt[g].press;
    assign rel_p[g]   = evt[g].rel;
  end

  // Only the rising edge of the registered ack acts, so a held bit clears once.
  assign ack_edge = ack_r & ~ack_prev;

  // Set beats clear on flags; a same-cycle count clear and press leaves 1.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ack_r      <= '0;
      ack_prev   <= '0;
      press_flag <= '0;
      press_cnt  <= '0;
      evt_irq    <= 1'b0;
    end else begin
      ack_r    <= xack;
      ack_prev <= ack_r;
      for (int i = 0; i < N_BTN; i++) begin
        press_flag[i] <= press_p[i] | (press_flag[i] & ~ack_edge[ACK_FLAG_LSB + i]);
        if (ack_edge[ACK_CNT_LSB + i])
          press_cnt[i] <= {{(CNT_W-1){1'b0}}, press_p[i]};
        else if (press_p[i])
          press_cnt[i] <= press_cnt[i] + 1'b1;
      end
      evt_irq <= (|press_flag) | (|rel_flag);
    end
  end

`ifdef BTN_RELEASE_EVT_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rel_flag <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++)
        rel_flag[i] <= rel_p[i] | (rel_flag[i] & ~ack_edge[ACK_FLAG_LSB + i]);
    end
  end
`else
  logic unused_rel;
  assign rel_flag   = '0;
  assign unused_rel = ^rel_p;
`endif

  logic unused_ack;
  assign unused_ack = ^ack_edge;

  always_comb begin
    xstat                 = '0;
    xstat[ID_LSB +: 8]    = BTN_STATUS_ID;
    for (int i = 0; i < N_BTN; i++) begin
      xstat[LVL_LSB + i]                    = lvl[i];
      xstat[PRESS_LSB + i]                  = press_flag[i];
      xstat[REL_LSB + i]                    = rel_flag[i];
      xstat[CNT0_LSB + CNT_W*i +: CNT_W]    = press_cnt[i];
    end
  end

endmodule

// File: tb/tb_btn_status.sv
// Randomised + directed bench for btn_status with a scoreboarded reference model.
module tb_btn_status;

  localparam int D = 4;

  logic        clock, resetn;
  logic [1:0]  btn_n;
  logic [31:0] xack, xstat;
  logic        evt_irq;

  int n_cmp = 0;
  int n_bad = 0;

  btn_status #(.N_BTN(2), .p_CNT_DEBOUNCE(D)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .btn_n   (btn_n),
    .xack    (xack),
    .xstat   (xstat),
    .evt_irq (evt_irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Reference model: pin history as a delay line, debounce as "D consecutive
  // disagreeing samples since the last accepted change".
  typedef struct packed { logic [31:0] st; logic irq; } exp_t;
  exp_t sb_q[$];

  bit          m_hist[2][$];
  bit          m_mis[2][$];
  bit          m_d[2], m_pp[2], m_rp[2], m_pf[2], m_rf[2], m_irq;
  logic [7:0]  m_cnt[2];
  logic [31:0] m_ackr, m_ackp;

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_hist[i] = '{1'b1, 1'b1};
      m_mis[i].delete();
      m_d[i] = 1; m_pp[i] = 0; m_rp[i] = 0; m_pf[i] = 0; m_rf[i] = 0;
      m_cnt[i] = 8'd0;
    end
    m_irq = 0; m_ackr = '0; m_ackp = '0;
  endtask

  task automatic m_step();
    logic [31:0] ae;
    bit any, s, all;
    ae  = m_ackr & ~m_ackp;
    any = m_pf[0] | m_pf[1] | m_rf[0] | m_rf[1];
    for (int i = 0; i < 2; i++) begin
      m_pf[i] = m_pp[i] | (m_pf[i] & ~ae[i]);
`ifdef BTN_RELEASE_EVT_EN
      m_rf[i] = m_rp[i] | (m_rf[i] & ~ae[i]);
`endif
      if (ae[8+i]) m_cnt[i] = {7'd0, m_pp[i]};
      else         m_cnt[i] = m_cnt[i] + 8'(m_pp[i]);
      s = m_hist[i][1];
      m_mis[i].push_back(s != m_d[i]);
      if (m_mis[i].size() > D) void'(m_mis[i].pop_front());
      all = (m_mis[i].size() == D);
      foreach (m_mis[i][k]) all &= m_mis[i][k];
      m_pp[i] = 0; m_rp[i] = 0;
      if (all) begin
        m_d[i]  = s;
        m_pp[i] = !s;
        m_rp[i] = s;
        m_mis[i].delete();
      end
      m_hist[i].push_front(btn_n[i]);
      void'(m_hist[i].pop_back());
    end
    m_ackp = m_ackr;
    m_ackr = xack;
    m_irq  = any;
  endtask

  initial begin
    m_reset();
    forever begin
      exp_t e;
      @(posedge clock);
      if (!resetn) m_reset();
      else         m_step();
      e.st  = {8'hB5, m_cnt[1], m_cnt[0], m_rf[1], m_rf[0], m_pf[1], m_pf[0], 2'b00, !m_d[1], !m_d[0]};
      e.irq = m_irq;
      sb_q.push_back(e);
    end
  end

  initial begin
    forever begin
      exp_t e;
      @(posedge clock);
      #1;
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk("sb_xstat", xstat, e.st);
        chk("sb_irq", {31'd0, evt_irq}, {31'd0, e.irq});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 0; btn_n = 2'b11; xack = '0;
    repeat (3) tick();
    resetn = 1;

    // idle after reset
    repeat (100) tick();
    chk("idle_stat", xstat, 32'hB500_0000);
    chk("idle_irq", {31'd0, evt_irq}, 32'd0);

    // press latency and event ordering
    btn_n[0] = 0;
    repeat (5) tick(); chk("lat_before", {31'd0, xstat[0]}, 32'd0);
    tick();            chk("lat_at", {31'd0, xstat[0]}, 32'd1);
    tick();
    chk("pflag", {31'd0, xstat[4]}, 32'd1);
    chk("cnt0_1", {24'd0, xstat[15:8]}, 32'd1);
    chk("irq_lag", {31'd0, evt_irq}, 32'd0);
    tick();            chk("irq_set", {31'd0, evt_irq}, 32'd1);

    // short glitches on button 1 never register
    repeat (5) begin
      btn_n[1] = 0; repeat (3) tick();
      btn_n[1] = 1; repeat (3) tick();
    end
    repeat (8) tick();
    chk("glitch", {22'd0, xstat[23:16], xstat[5], xstat[1]}, 32'd0);

    // ack clears once; held ack does not swallow a later press
    xack = 32'h1; tick(); xack = '0;
    repeat (5) tick();
    chk("ack_flag", {31'd0, xstat[4]}, 32'd0);
    chk("ack_irq", {31'd0, evt_irq}, 32'd0);
    xack = 32'h1;
    btn_n[0] = 1; repeat (10) tick();
`ifdef BTN_RELEASE_EVT_EN
    chk("rel_flag", {31'd0, xstat[6]}, 32'd1);
    chk("rel_irq", {31'd0, evt_irq}, 32'd1);
`else
    chk("rel_absent", {30'd0, xstat[7:6]}, 32'd0);
`endif
    btn_n[0] = 0; repeat (10) tick();
    chk("held_ack_set", {31'd0, xstat[4]}, 32'd1);
    repeat (10) tick();
    chk("held_ack_keep", {31'd0, xstat[4]}, 32'd1);
    xack = '0; tick();

    // counter wrap after 256 presses
    xack = 32'h100; tick(); xack = '0; repeat (3) tick();
    chk("cnt_clr", {24'd0, xstat[15:8]}, 32'd0);
    repeat (256) begin
      btn_n[0] = 1; repeat (8) tick();
      btn_n[0] = 0; repeat (8) tick();
    end
    chk("cnt_wrap", {24'd0, xstat[15:8]}, 32'd0);
    btn_n[0] = 1; repeat (8) tick();
    btn_n[0] = 0; repeat (8) tick();
    btn_n[0] = 1; repeat (8) tick();
    chk("cnt_one", {24'd0, xstat[15:8]}, 32'd1);

    // press increment lands on the same edge as a count clear
    btn_n[0] = 0; repeat (5) tick();
    xack = 32'h100; tick(); xack = '0;
    repeat (4) tick();
    chk("cnt_coinc", {24'd0, xstat[15:8]}, 32'd1);

    // reset mid-debounce, button held through release
    btn_n = 2'b11; repeat (8) tick();
    btn_n[1] = 0; repeat (3) tick();
    resetn = 0; #1;
    chk("rst_async", xstat, 32'hB500_0000);
    chk("rst_irq", {31'd0, evt_irq}, 32'd0);
    repeat (3) tick();
    resetn = 1;
    repeat (5) tick(); chk("rst_hold_pre", {31'd0, xstat[1]}, 32'd0);
    tick();            chk("rst_hold_at", {31'd0, xstat[1]}, 32'd1);

    // randomised pins and acks against the model
    btn_n = 2'b11; repeat (8) tick();
    repeat (300) begin
      btn_n = 2'($urandom);
      xack  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_0303) : 32'h0;
      repeat ($urandom_range(1, 12)) tick();
    end
    xack = '0; btn_n = 2'b11;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
